mpu_sampler: RTL and testbench
==============================

# mpu_sampler

Periodic sampling controller for the `mpu` I2C block driving the MPU6050. After reset it issues a one-time `mpu_init` and waits for `init_done`. It then fires `mpu_transfer` at a fixed sample rate and assembles the 14 returned bytes into seven signed 16-bit words. Each complete frame is published atomically with a one-cycle strobe to the attitude/control logic downstream.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `SAMPLE_HZ`, 500: frame request rate. Divider `DIV = CLK_HZ/SAMPLE_HZ`, which must be ≥ 2.
- `FRAME_BYTES`, 14: bytes per burst, register order 0x3B..0x48.
- `TIMEOUT_CYC`, 100_000: cycle limit for the init wait and for the byte collection of one frame.
- `INIT_RETRY`, 3: number of init attempts before fatal error.

Ports:
- `clk`  in  1  system clock; everything in this block is on this clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new frame requests.
- `mpu_init`  out  1  one-cycle init request to `mpu`.
- `mpu_transfer`  out  1  one-cycle burst-read request to `mpu`.
- `init_done`  in  1  level; high once `mpu` configuration has completed.
- `busy_now`  in  1  `mpu` I2C engine is active.
- `data_avalid`  in  1  one-cycle strobe per received byte.
- `data`  in  8  received byte, valid while `data_avalid` is high.
- `accel_x`, `accel_y`, `accel_z`, `temp`, `gyro_x`, `gyro_y`, `gyro_z`  out  16 each  published frame words, two's complement.
- `frame_valid`  out  1  one-cycle strobe; the published words have just updated.
- `frame_cnt`  out  16  count of published frames; wraps from 0xFFFF to 0.
- `overrun`  out  1  sticky; a tick arrived while a frame was still in flight.
- `err_cnt`  out  8  count of timed-out frames; saturates at 255.
- `fatal`  out  1  sticky; init retries are exhausted.

## Operation
- FSM states: `INIT_REQ`, `INIT_WAIT`, `ARMED`, `XFER_REQ`, `COLLECT`, `PUBLISH`, `FATAL`.
- **Reset:** the FSM enters `INIT_REQ`. Every output is cleared: all data words 0, counters 0, flags 0, strobes 0.
- **`INIT_REQ`:** pulses `mpu_init` for one cycle, then moves to `INIT_WAIT`. The timeout counter is cleared.
- **`INIT_WAIT`:**
  - `init_done` high → `ARMED`.
  - Timeout reached → retry count increments and the FSM returns to `INIT_REQ`.
  - After `INIT_RETRY` failed attempts → `FATAL`.
- **`FATAL`:** absorbing state; `fatal` is high. Only `rst_n` leaves it.
- **Rate tick:**
  - A free-running divider runs from reset, independent of the FSM state.
  - The tick is a one-cycle pulse every `DIV` cycles.
  - Ticks are accepted only in `ARMED` with `enable` high.
- **`ARMED`:** an accepted tick → `XFER_REQ`.
- **`XFER_REQ`:**
  - Waits for `busy_now` low, then pulses `mpu_transfer` for one cycle.
  - Clears the byte index and the timeout counter, then moves to `COLLECT`.
- **`COLLECT`:**
  - Each `data_avalid` writes `data` into the shadow buffer at the current byte index, then increments the index.
  - Even index → high byte of the word, odd index → low byte (big-endian).
  - Word order: `accel_x`, `accel_y`, `accel_z`, `temp`, `gyro_x`, `gyro_y`, `gyro_z`.
  - When byte `FRAME_BYTES-1` is written → `PUBLISH`.
  - Timeout reached → the shadow buffer is discarded, `err_cnt` increments, and the FSM returns to `ARMED`. The published words are unchanged.
- **`PUBLISH`:** copies all seven shadow words to the outputs in one cycle. Asserts `frame_valid`, increments `frame_cnt`, then moves to `ARMED`.
- **Overrun:** a tick occurring in `XFER_REQ`, `COLLECT` or `PUBLISH` sets `overrun`. The tick is dropped, not queued.
- **`enable` low:** no new request is issued. A frame already in flight completes normally.
- **`data_avalid` outside `COLLECT`:** ignored.

## Timing
- `mpu_init` is high exactly in the cycle after reset release. It is pulsed again on each retry.
- `mpu_transfer` is asserted in the cycle after the accepted tick when `busy_now` is low. Otherwise it is asserted in the first cycle after `busy_now` falls.
- Publish latency: `frame_valid` is high in the cycle after the final byte's `data_avalid` is sampled.
  - Output words change in that same cycle.
  - They are otherwise stable; there is never a partial update.
- Timeout counters count from state entry. The condition is met when the count equals `TIMEOUT_CYC-1`.
- A tick coincident with the `PUBLISH` cycle counts as an overrun. A tick in the cycle after `PUBLISH` is accepted.
- `rst_n` assertion mid-burst aborts immediately. After release the block restarts from `INIT_REQ`.

## Structure
- Shared include `mpu_defs.vh` holds:
  - the state encodings;
  - `FRAME_BYTES`;
  - the word-index constants (`W_AX`..`W_GZ`);
  - the MPU6050 burst start address 0x3B, for consistency with `mpu`.
- Sub-module `rate_tick`: the parameterized divider, with ports `clk`, `rst_n`, `tick`.
- The FSM, shadow buffer and counters stay in `mpu_sampler`.

## Test plan
1. **Init:** `init_done` rises 200 cycles after `mpu_init` → `ARMED`; one `mpu_init` pulse only; `fatal` = 0.
2. **Init failure:** `init_done` is held low with `TIMEOUT_CYC` = 1000 → three `mpu_init` pulses 1001 cycles apart, then `fatal` = 1.
3. **Frame assembly:** the model returns bytes 0x01..0x0E → `accel_x` = 0x0102 … `gyro_z` = 0x0D0E; one `frame_valid` pulse; `frame_cnt` = 1.
4. **Byte timeout:** only 9 bytes are returned → after the timeout, `err_cnt` = 1, outputs keep their previous frame, and the next tick produces a normal frame.
5. **Overrun and busy:** with `DIV` = 100 and bursts taking 150 cycles, `overrun` = 1 and requests occur every 200 cycles. With `busy_now` held high for 30 cycles after the tick, `mpu_transfer` follows `busy_now` falling by 1 cycle.
6. **Reset mid-burst:** `rst_n` is pulsed low during byte 7 → all outputs are 0 immediately, and `mpu_init` pulses again after release.

Source files
------------

// File: rtl/mpu_sampler_pkg.sv
// Shared definitions for the MPU6050 sampling controller: FSM states, frame
// layout and the burst start register.
package mpu_sampler_pkg;

  typedef enum logic [2:0] {
    S_INIT_REQ,
    S_INIT_WAIT,
    S_ARMED,
    S_XFER_REQ,
    S_COLLECT,
    S_PUBLISH,
    S_FATAL
  } state_t;

  localparam int FRAME_BYTES = 14;
  localparam int NUM_WORDS   = FRAME_BYTES / 2;

  localparam int W_AX = 0;
  localparam int W_AY = 1;
  localparam int W_AZ = 2;
  localparam int W_T  = 3;
  localparam int W_GX = 4;
  localparam int W_GY = 5;
  localparam int W_GZ = 6;

  // First register of the burst (ACCEL_XOUT_H); must match the mpu block.
  localparam logic [7:0] MPU_BURST_ADDR = 8'h3B;

  function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mpu_sampler_rate_tick.sv
// Free-running divider: one-cycle tick every DIV clocks, phase set by reset.
module rate_tick #(
  parameter int DIV = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= LOAD;
    else if (cnt == '0)  cnt <= LOAD;
    else                 cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/mpu_sampler.sv
// Periodic MPU6050 sampler: one-time init, rate-driven burst reads, and atomic
// publication of the seven big-endian sensor words.
//
// state       | meaning
// INIT_REQ    | pulse mpu_init, arm init timeout
// INIT_WAIT   | wait for init_done; retry or give up on timeout
// ARMED       | idle, waiting for an accepted rate tick
// XFER_REQ    | tick accepted but mpu busy; request once busy_now drops
// COLLECT     | gather burst bytes into the shadow buffer
// PUBLISH     | frame_valid cycle, outputs hold the new frame
// FATAL       | init retries exhausted, only reset leaves
module mpu_sampler
  import mpu_sampler_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SAMPLE_HZ   = 500,
  parameter int TIMEOUT_CYC = 100_000,
  parameter int INIT_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        mpu_init,
  output logic        mpu_transfer,
  input  logic        init_done,
  input  logic        busy_now,
  input  logic        data_avalid,
  input  logic [7:0]  data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] temp,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        frame_valid,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic [7:0]  err_cnt,
  output logic        fatal
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int RW  = $clog2(INIT_RETRY + 1);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(INIT_RETRY - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(FRAME_BYTES - 1);

  state_t        state;
  logic          tick;
  logic [TW-1:0] tmr;
  logic [RW-1:0] retry;
  logic [3:0]    idx;
  logic [15:0]   shadow [NUM_WORDS];

  rate_tick #(.DIV(DIV)) u_rate_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT_REQ;
      tmr          <= '0;
      retry        <= '0;
      idx          <= '0;
      for (int i = 0; i < NUM_WORDS; i++) shadow[i] <= '0;
      mpu_init     <= 1'b0;
      mpu_transfer <= 1'b0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      temp         <= '0;
      gyro_x       <= '0;
      gyro_y       <= '0;
      gyro_z       <= '0;
      frame_valid  <= 1'b0;
      frame_cnt    <= '0;
      overrun      <= 1'b0;
      err_cnt      <= '0;
      fatal        <= 1'b0;
    end else begin
      mpu_init     <= 1'b0;
      mpu_transfer <= 1'b0;
      frame_valid  <= 1'b0;

      if (tick && (state == S_XFER_REQ || state == S_COLLECT || state == S_PUBLISH))
        overrun <= 1'b1;

      case (state)
        S_INIT_REQ: begin
          mpu_init <= 1'b1;
          tmr      <= TMR_LOAD;
          state    <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          if (init_done) begin
            state <= S_ARMED;
          end else if (tmr == '0) begin
            if (retry == RETRY_MAX) begin
              fatal <= 1'b1;
              state <= S_FATAL;
            end else begin
              retry <= retry + 1'b1;
              state <= S_INIT_REQ;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        // An idle engine lets the request go out directly from ARMED so
        // mpu_transfer lands in the cycle right after the tick.
        S_ARMED, S_XFER_REQ: begin
          if (state == S_XFER_REQ || (tick && enable)) begin
            if (!busy_now) begin
              mpu_transfer <= 1'b1;
              idx          <= '0;
              tmr          <= TMR_LOAD;
              state        <= S_COLLECT;
            end else begin
              state <= S_XFER_REQ;
            end
          end
        end
        S_COLLECT: begin
          if (data_avalid && idx == LAST_IDX) begin
            accel_x     <= shadow[W_AX];
            accel_y     <= shadow[W_AY];
            accel_z     <= shadow[W_AZ];
            temp        <= shadow[W_T];
            gyro_x      <= shadow[W_GX];
            gyro_y      <= shadow[W_GY];
            gyro_z      <= be_word(shadow[W_GZ][15:8], data);
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 1'b1;
            state       <= S_PUBLISH;
          end else begin
            if (data_avalid) begin
              if (!idx[0]) shadow[idx[3:1]][15:8] <= data;
              else         shadow[idx[3:1]][7:0]  <= data;
              idx <= idx + 1'b1;
            end
            if (tmr == '0) begin
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
              state <= S_ARMED;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
        end
        S_PUBLISH: state <= S_ARMED;
        S_FATAL:   fatal <= 1'b1;
        default:   state <= S_INIT_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_sampler.sv
// Self-checking bench for mpu_sampler: vector table, randomized frames against
// a byte-to-word model, and hand-written timeout/overrun/busy/reset sequences.
module tb_mpu_sampler;

  localparam int CLK_HZ      = 100_000;
  localparam int SAMPLE_HZ   = 1_000;   // DIV = 100
  localparam int TIMEOUT_CYC = 1000;
  localparam int INIT_RETRY  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        init_done = 1'b0;
  logic        busy_now = 1'b0;
  logic        data_avalid = 1'b0;
  logic [7:0]  data = '0;
  logic        mpu_init, mpu_transfer, frame_valid, overrun, fatal;
  logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z, frame_cnt;
  logic [7:0]  err_cnt;

  mpu_sampler #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ),
    .TIMEOUT_CYC(TIMEOUT_CYC), .INIT_RETRY(INIT_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .mpu_init(mpu_init), .mpu_transfer(mpu_transfer),
    .init_done(init_done), .busy_now(busy_now),
    .data_avalid(data_avalid), .data(data),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .frame_valid(frame_valid), .frame_cnt(frame_cnt), .overrun(overrun),
    .err_cnt(err_cnt), .fatal(fatal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  fb [14];
  logic [15:0] ew [7];
  logic [15:0] exp_w [7];
  int          exp_frames = 0;
  int          t_xfer = 0;

  logic [15:0] dut_w [7];
  assign dut_w[0] = accel_x;
  assign dut_w[1] = accel_y;
  assign dut_w[2] = accel_z;
  assign dut_w[3] = temp;
  assign dut_w[4] = gyro_x;
  assign dut_w[5] = gyro_y;
  assign dut_w[6] = gyro_z;

  typedef struct packed {
    logic [111:0] in_bytes;
    logic [111:0] exp_words;
  } vec_t;
  vec_t vecs [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name, input int waited);
    n_chk++;
    $display("FAIL %s: no event after %0d cycles, expected one", name, waited);
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s_w%0d", tag, i), dut_w[i], exp_w[i]);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_words"}, |{accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z}, 0);
    check({tag, "_cnts"}, {frame_cnt, err_cnt}, 0);
    check({tag, "_flags"}, {mpu_init, mpu_transfer, frame_valid, overrun, fatal}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; init_done = 1'b0; busy_now = 1'b0;
    data_avalid = 1'b0; data = '0;
    exp_frames = 0;
    for (int i = 0; i < 7; i++) exp_w[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("init_pulse_after_release", mpu_init, 1);
  endtask

  task automatic wait_xfer(input int maxc);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mpu_transfer && w < maxc);
    if (!mpu_transfer) fail_bound("wait_xfer", w);
    else t_xfer = cyc;
  endtask

  task automatic send_bytes(input int nb, input int gmin, input int gmax);
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      if (i == 13) begin
        check("no_partial_fv", frame_valid, 0);
        check_words("no_partial");
      end
      data = fb[i];
      data_avalid = 1'b1;
      @(negedge clk);
      data_avalid = 1'b0;
    end
  endtask

  task automatic do_frame(input string tag, input bit wait_x, input int gmin, input int gmax);
    if (wait_x) wait_xfer(300);
    send_bytes(14, gmin, gmax);
    exp_frames++;
    for (int i = 0; i < 7; i++) exp_w[i] = ew[i];
    check({tag, "_fv"}, frame_valid, 1);
    check_words(tag);
    check({tag, "_cnt"}, frame_cnt, 16'(exp_frames));
    @(negedge clk);
    check({tag, "_fv_single"}, frame_valid, 0);
  endtask

  // Reference: each word is the big-endian pair of consecutive bytes.
  task automatic model_words();
    for (int i = 0; i < 7; i++)
      ew[i] = 16'(int'(fb[2*i]) * 256 + int'(fb[2*i+1]));
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 14; i++) fb[i] = 8'($urandom_range(255, 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int pulses, xf, t1, t2, t3, np, frise;
    int p [4];
    logic [111:0] tb_bytes, tb_words;

    vecs[0] = '{112'h0102030405060708090A0B0C0D0E, 112'h0102_0304_0506_0708_090A_0B0C_0D0E};
    vecs[1] = '{112'h80007FFFFFFF00011234ABCDFEDC, 112'h8000_7FFF_FFFF_0001_1234_ABCD_FEDC};
    vecs[2] = '{112'hFF0000FF5AA5A55A0000FFFF0FF0, 112'hFF00_00FF_5AA5_A55A_0000_FFFF_0FF0};

    // Init: init_done 200 cycles after the mpu_init pulse
    do_reset();
    pulses = 1; xf = 0;
    repeat (199) begin @(negedge clk); pulses += int'(mpu_init); end
    init_done = 1'b1;
    repeat (300) begin
      @(negedge clk);
      pulses += int'(mpu_init);
      xf += int'(mpu_transfer);
    end
    check("init_single_pulse", pulses, 1);
    check("init_no_fatal", fatal, 0);
    check("no_xfer_enable_low", xf, 0);

    enable = 1'b1;
    for (int v = 0; v < 3; v++) begin
      tb_bytes = vecs[v].in_bytes;
      tb_words = vecs[v].exp_words;
      for (int i = 0; i < 14; i++) fb[i] = tb_bytes[111 - 8*i -: 8];
      for (int i = 0; i < 7; i++)  ew[i] = tb_words[111 - 16*i -: 16];
      do_frame($sformatf("vec%0d", v), 1'b1, 0, 2);
    end

    for (int r = 0; r < 6; r++) begin
      rand_bytes();
      model_words();
      do_frame($sformatf("rnd%0d", r), 1'b1, 0, 3);
    end
    check("no_overrun_fast_frames", overrun, 0);
    check("no_err_yet", err_cnt, 0);

    // Slow bursts (~155 cycles) against a 100-cycle tick
    rand_bytes(); model_words(); do_frame("slow0", 1'b1, 10, 10); t1 = t_xfer;
    rand_bytes(); model_words(); do_frame("slow1", 1'b1, 10, 10); t2 = t_xfer;
    rand_bytes(); model_words(); do_frame("slow2", 1'b1, 10, 10); t3 = t_xfer;
    check("req_period_a", t2 - t1, 200);
    check("req_period_b", t3 - t2, 200);
    check("overrun_set", overrun, 1);

    // Busy engine holds the request until busy_now falls
    busy_now = 1'b1; xf = 0;
    repeat (150) begin @(negedge clk); xf += int'(mpu_transfer); end
    check("no_xfer_while_busy", xf, 0);
    busy_now = 1'b0;
    @(negedge clk);
    check("xfer_after_busy_fall", mpu_transfer, 1);
    rand_bytes(); model_words(); do_frame("busy", 1'b0, 0, 2);

    // Byte timeout: 9 of 14 bytes, enable dropped while in flight
    wait_xfer(300);
    enable = 1'b0;
    rand_bytes();
    for (int k = 0; k <= 1000; k++) begin
      if (k == 999)  check("to_err_before", err_cnt, 0);
      if (k == 1000) check("to_err_at", err_cnt, 1);
      data_avalid = (k < 9);
      if (k < 9) data = fb[k];
      @(negedge clk);
    end
    data_avalid = 1'b0;
    check_words("to_hold");
    check("to_cnt_hold", frame_cnt, 16'(exp_frames));
    enable = 1'b1;
    rand_bytes(); model_words(); do_frame("after_to", 1'b1, 0, 3);

    // Reset asserted during byte 7
    wait_xfer(300);
    rand_bytes();
    send_bytes(7, 0, 0);
    data = fb[7];
    data_avalid = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_zero("rst_mid");
    do_reset();

    // Init failure: init_done never rises
    np = 1; frise = -1;
    p = '{default: 0};
    p[0] = cyc;
    repeat (3500) begin
      @(negedge clk);
      if (mpu_init) begin
        if (np < 4) p[np] = cyc;
        np++;
      end
      if (fatal && frise < 0) frise = cyc;
    end
    check("fail_init_pulses", np, 3);
    check("fail_gap1", p[1] - p[0], 1001);
    check("fail_gap2", p[2] - p[1], 1001);
    check("fail_fatal", fatal, 1);
    check("fail_fatal_time", frise - p[2], 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
